// File: rtl/rf_writeback_queue.sv
// Writeback queue in front of the register file's single write port.
// Drops x0 writes, drains one entry per cycle, and exposes a youngest-match lookup for forwarding.
module rf_writeback_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wb_valid,
   output logic                     wb_ready,
   input  logic [AW-1:0]            wb_rd,
   input  logic [DW-1:0]            wb_data,
   input  logic                     rf_ready,
   output logic                     WE3,
   output logic [AW-1:0]            A3,
   output logic [DW-1:0]            WD3,
   input  logic [AW-1:0]            look_addr,
   output logic                     look_hit,
   output logic [DW-1:0]            look_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [AW-1:0] rd_mem   [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];
   logic [PW-1:0] head_q, tail_q;
   logic [CW-1:0] cnt_q;
   logic          push, pop, occupied;
   logic [PW-1:0] idx;

   // Handshake and drain; outputs are forced quiet while reset is held.
   always_comb begin
      occupied = !reset && (cnt_q != '0);
      wb_ready = !reset && (cnt_q < FULL);
      push     = wb_valid && wb_ready && (wb_rd != '0);
      WE3      = occupied && rf_ready;
      pop      = WE3;
      count    = reset ? '0 : cnt_q;
      empty    = (count == '0);
      A3       = '0;
      WD3      = '0;
      if (occupied) begin
         A3  = rd_mem[head_q];
         WD3 = data_mem[head_q];
      end
   end

   // Walk oldest to youngest so the last match found is the youngest writer.
   always_comb begin
      look_hit  = 1'b0;
      look_data = '0;
      idx       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if (!reset && (look_addr != '0) && (CW'(i) < cnt_q) && (rd_mem[idx] == look_addr)) begin
            look_hit  = 1'b1;
            look_data = data_mem[idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) tail_q <= tail_q + PW'(1);
         if (pop)  head_q <= head_q + PW'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Entry storage carries no reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[tail_q]   <= wb_rd;
         data_mem[tail_q] <= wb_data;
      end
   end

endmodule
